// File: rtl/flash_seq_pkg.sv
// flash_seq_pkg: command codes, FSM states and default timings shared by the flash op sequencer
package flash_seq_pkg;
    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_WREN = 3'd1;
    localparam logic [2:0] CMD_WRDI = 3'd2;
    localparam logic [2:0] CMD_READ = 3'd3;
    localparam logic [2:0] CMD_PP   = 3'd4;
    localparam logic [2:0] CMD_SE   = 3'd5;
    localparam logic [2:0] CMD_BE   = 3'd6;
    localparam int NB_BIT_ADD_MEM_DEF = 16;
    localparam int T_PP_CYC_DEF       = 5000;
    localparam int T_SE_CYC_DEF       = 200000;
    localparam int T_BE_CYC_DEF       = 400000;
    localparam int CNT_W_DEF          = 24;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_PP_LOAD,
        ST_PP_COMMIT,
        ST_PP_BUSY,
        ST_SE_BUSY,
        ST_BE_BUSY
    } state_t;
endpackage

// File: rtl/flash_busy_timer.sv
// flash_busy_timer: loadable down-counter with zero flag and freeze, times program/erase busy periods
module flash_busy_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             freeze,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    // load wins over counting; counting stops at zero and while frozen
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (!freeze && cnt != '0) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/flash_op_sequencer.sv
// flash_op_sequencer: sequences read/program/erase enables to the flash array; optional FLASH_SEQ_SUSPEND_EN adds an erase-suspend input
module flash_op_sequencer
    import flash_seq_pkg::*;
#(
    parameter int NB_BIT_ADD_MEM = NB_BIT_ADD_MEM_DEF,
    parameter int T_PP_CYC       = T_PP_CYC_DEF,
    parameter int T_SE_CYC       = T_SE_CYC_DEF,
    parameter int T_BE_CYC       = T_BE_CYC_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_code,
    input  logic [NB_BIT_ADD_MEM-1:0] cmd_addr,
    input  logic                      byte_tick,
    input  logic                      op_end,
`ifdef FLASH_SEQ_SUSPEND_EN
    input  logic                      suspend,
`endif
    output logic [NB_BIT_ADD_MEM-1:0] add_mem_extern,
    output logic                      read_enable,
    output logic                      data_request,
    output logic                      add_pp_enable,
    output logic                      pp_enable,
    output logic                      se_enable,
    output logic                      be_enable,
    output logic                      wip,
    output logic                      wel,
    output logic                      cmd_err
);
    state_t state, state_n;
    logic [NB_BIT_ADD_MEM-1:0] addr_n;
    logic rdy_n, rd_n, dr_n, app_n, pp_n, se_n, be_n, wip_n, wel_n, err_n;
    logic load, zero, freeze, done;
    logic [CNT_W-1:0] load_val;
`ifdef FLASH_SEQ_SUSPEND_EN
    assign freeze = suspend && (state == ST_SE_BUSY || state == ST_BE_BUSY);
`else
    assign freeze = 1'b0;
`endif
    assign done = zero && !freeze;
    flash_busy_timer #(.CNT_W(CNT_W)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_val(load_val),
        .freeze(freeze),
        .zero(zero)
    );
    // state and every output are registered; reset drops all enables at once
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= ST_IDLE;
            add_mem_extern <= '0;
            {cmd_ready, read_enable, data_request, add_pp_enable, pp_enable} <= '0;
            {se_enable, be_enable, wip, wel, cmd_err} <= '0;
        end else begin
            state <= state_n;
            add_mem_extern <= addr_n;
            {cmd_ready, read_enable, data_request, add_pp_enable, pp_enable} <= {rdy_n, rd_n, dr_n, app_n, pp_n};
            {se_enable, be_enable, wip, wel, cmd_err} <= {se_n, be_n, wip_n, wel_n, err_n};
        end
    // next-state and next-output decode; pp_enable rises one clock before add_pp_enable falls
    always_comb begin
        state_n = state;
        addr_n = add_mem_extern;
        {rd_n, app_n, pp_n, se_n, be_n, wip_n, wel_n} = {read_enable, add_pp_enable, pp_enable, se_enable, be_enable, wip, wel};
        dr_n = 1'b0;
        err_n = 1'b0;
        load = 1'b0;
        load_val = '0;
        case (state)
            ST_IDLE: if (cmd_valid && cmd_ready) begin
                case (cmd_code)
                    CMD_WREN: wel_n = 1'b1;
                    CMD_WRDI: wel_n = 1'b0;
                    CMD_READ: begin
                        addr_n = cmd_addr;
                        rd_n = 1'b1;
                        state_n = ST_RD;
                    end
                    CMD_PP: if (wel) begin
                        addr_n = cmd_addr;
                        app_n = 1'b1;
                        state_n = ST_PP_LOAD;
                    end else err_n = 1'b1;
                    CMD_SE: if (wel) begin
                        addr_n = cmd_addr;
                        {se_n, wip_n, load} = 3'b111;
                        load_val = CNT_W'(T_SE_CYC - 1);
                        state_n = ST_SE_BUSY;
                    end else err_n = 1'b1;
                    CMD_BE: if (wel) begin
                        {be_n, wip_n, load} = 3'b111;
                        load_val = CNT_W'(T_BE_CYC - 1);
                        state_n = ST_BE_BUSY;
                    end else err_n = 1'b1;
                    default: ;
                endcase
            end
            ST_RD: begin
                dr_n = byte_tick;
                if (op_end) begin
                    rd_n = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            ST_PP_LOAD: if (op_end) begin
                {pp_n, wip_n} = 2'b11;
                state_n = ST_PP_COMMIT;
            end
            ST_PP_COMMIT: begin
                app_n = 1'b0;
                load = 1'b1;
                load_val = CNT_W'(T_PP_CYC - 2);
                state_n = ST_PP_BUSY;
            end
            ST_PP_BUSY: if (zero) begin
                {pp_n, wip_n, wel_n} = 3'b000;
                state_n = ST_IDLE;
            end
            ST_SE_BUSY: if (done) begin
                {se_n, wip_n, wel_n} = 3'b000;
                state_n = ST_IDLE;
            end
            ST_BE_BUSY: if (done) begin
                {be_n, wip_n, wel_n} = 3'b000;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        rdy_n = state_n == ST_IDLE;
    end
endmodule

// File: doc/flash_op_sequencer.md
Name: flash_op_sequencer

Overview:
- Clocked controller that drives the flash array model's operation enables from decoded serial-flash instructions.
- Sits between the instruction decoder and the memory array datapath.
- Accepts one command at a time and sequences read, page-program, sector-erase and bulk-erase enable waveforms in the required edge order.
- Times the busy periods with a cycle counter and maintains the WIP/WEL status bits.

Parameters:
- NB_BIT_ADD_MEM, 16, array address width.
- T_PP_CYC, 5000, clocks pp_enable is held high (program busy).
- T_SE_CYC, 200000, clocks se_enable is held high (sector erase busy).
- T_BE_CYC, 400000, clocks be_enable is held high (bulk erase busy).
- CNT_W, 24, busy-counter width; must satisfy 2^CNT_W > max T_*_CYC.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_code  in  3  0=NOP 1=WREN 2=WRDI 3=READ 4=PP 5=SE 6=BE, others NOP
- cmd_addr  in  NB_BIT_ADD_MEM  start address for READ/PP/SE
- byte_tick  in  1  one-clock pulse per serial byte boundary during READ
- op_end  in  1  chip-select release; ends READ and PP load phase
- add_mem_extern  out  NB_BIT_ADD_MEM  address to array
- read_enable  out  1
- data_request  out  1
- add_pp_enable  out  1
- pp_enable  out  1
- se_enable  out  1
- be_enable  out  1
- wip  out  1  write/erase in progress
- wel  out  1  write-enable latch
- cmd_err  out  1  one-clock pulse on a rejected command

Behaviour:
- Reset: all outputs 0, add_mem_extern=0, state IDLE, counter 0.
  - Asynchronous reset mid-operation forces every enable low immediately.
  - The resulting falling edge on se_enable/be_enable is accepted; the array performs the erase.
- cmd_ready = 1 only in IDLE. All state changes occur on the clk rising edge after acceptance. All outputs are registered.
- WREN: wel<=1. WRDI: wel<=0. Both stay in IDLE.
- PP/SE/BE with wel=0: command is dropped, cmd_err pulses for 1 clock, stay IDLE.
- READ:
  - Accept -> add_mem_extern<=cmd_addr, read_enable<=1, state RD.
  - In RD, data_request = byte_tick delayed one clock: 1-clock high pulse per tick.
  - op_end -> read_enable<=0, data_request<=0, IDLE.
- PP:
  - Accept -> add_mem_extern<=cmd_addr, add_pp_enable<=1, state PP_LOAD.
  - On op_end -> state PP_COMMIT: pp_enable<=1, wip<=1, add_pp_enable stays 1 for exactly this clock.
    - Rationale: pp_enable must rise before add_pp_enable falls, because the falling edge clears the page buffer.
  - Next clock -> add_pp_enable<=0, counter<=T_PP_CYC-2, state PP_BUSY.
  - When counter==0 -> pp_enable<=0, wip<=0, wel<=0, IDLE.
  - pp_enable high time is exactly T_PP_CYC clocks.
- SE:
  - Accept -> add_mem_extern<=cmd_addr, se_enable<=1, wip<=1, counter<=T_SE_CYC-1, state SE_BUSY.
  - When counter==0 -> se_enable<=0, wip<=0, wel<=0, IDLE. The erase occurs on that falling edge.
- BE: same as SE using be_enable and T_BE_CYC; add_mem_extern is unchanged.
- Mutual exclusion: at most one of read_enable, se_enable, be_enable, pp_enable is high in any cycle. The only permitted overlap is add_pp_enable with pp_enable in PP_COMMIT.
- op_end outside RD/PP_LOAD is ignored. byte_tick outside RD is ignored.
- op_end and byte_tick in the same RD clock: the data_request pulse is still issued, then the block exits. data_request may be high in the first IDLE cycle.
- cmd_valid during a busy state is not accepted and is held by the source. It is not an error.

Optional Feature:
- FLASH_SEQ_SUSPEND_EN.
- When defined: input suspend (1 bit) freezes the busy counter while high in SE_BUSY/BE_BUSY.
  - Enables and wip stay high while frozen.
  - READ is still not accepted while frozen.
- When undefined: no suspend port; counters always run.

Decomposition:
- Shared package flash_seq_pkg holds:
  - command code constants CMD_NOP..CMD_BE
  - state encodings ST_IDLE, ST_RD, ST_PP_LOAD, ST_PP_COMMIT, ST_PP_BUSY, ST_SE_BUSY, ST_BE_BUSY
  - default timing constants
- One natural sub-module: flash_busy_timer (load, count-down, zero flag, optional freeze).

Test Plan:
- Reset then SE (cmd_code=5, addr 16'h1234) without WREN -> cmd_err 1 clock, se_enable stays 0, wel=0.
- WREN, then SE addr 16'h8000 with T_SE_CYC=10 -> se_enable high exactly 10 clocks, wip mirrors it, wel=0 after, cmd_ready back 1 clock later.
- WREN, PP addr 16'h0100, op_end after 4 byte times -> add_pp_enable and pp_enable overlap exactly 1 clock, pp_enable high T_PP_CYC clocks.
- READ addr 16'h0010, 3 byte_tick pulses, then op_end -> three 1-clock data_request pulses each 1 clock after its tick, read_enable falls the clock after op_end.
- WREN, BE, assert rst mid-busy -> all enables 0 asynchronously, wip=wel=0, cmd_ready=1 after rst release.
- During SE_BUSY, hold cmd_valid with READ -> cmd_ready=0 throughout, READ accepted the clock after return to IDLE.
